// File: rtl/memory_cycle_pkg.sv
// ----------------------------------------------------------------------------
// memory_cycle_pkg
//   Shared pipeline definitions for the memory-access stage: RV32I load/store
//   funct3 encodings, write-back result-select encodings and the state type of
//   the data-memory access FSM.
// ----------------------------------------------------------------------------
package memory_cycle_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Write-back result select: bit0 = memory data, bit1 = PC+4
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } mem_state_t;

endpackage

// File: rtl/memory_cycle_lsu_align.sv
// ----------------------------------------------------------------------------
// memory_cycle_lsu_align
//   Purely combinational byte-lane logic for the memory stage.
//   Ports:
//     is_store_i    access is a store (otherwise a load)
//     funct3_i      access size / sign
//     offset_i      byte offset within the word (address bits [1:0])
//     store_data_i  store source register
//     load_word_i   word returned by data memory
//     be_o          byte enables for the store
//     wdata_o       lane-replicated store data
//     load_data_o   extracted and extended load data
//     misaligned_o  access crosses its natural alignment
// ----------------------------------------------------------------------------
module memory_cycle_lsu_align
    import memory_cycle_pkg::*;
#(
    parameter int P_WIDTH = 32
) (
    input  logic               is_store_i,
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         offset_i,
    input  logic [P_WIDTH-1:0] store_data_i,
    input  logic [P_WIDTH-1:0] load_word_i,
    output logic [3:0]         be_o,
    output logic [P_WIDTH-1:0] wdata_o,
    output logic [P_WIDTH-1:0] load_data_o,
    output logic               misaligned_o
);

    logic               size_byte;
    logic               size_half;
    logic               sign_ext;
    logic [P_WIDTH-1:0] shifted;

    // Any funct3 not decoded as byte/half falls through to a full word access.
    always_comb begin
        size_byte = 1'b0;
        size_half = 1'b0;
        sign_ext  = 1'b0;
        if (is_store_i) begin
            size_byte = (funct3_i == F3_SB);
            size_half = (funct3_i == F3_SH);
        end else begin
            size_byte = (funct3_i == F3_LB) || (funct3_i == F3_LBU);
            size_half = (funct3_i == F3_LH) || (funct3_i == F3_LHU);
            sign_ext  = (funct3_i == F3_LB) || (funct3_i == F3_LH);
        end
    end

    assign misaligned_o = size_byte ? 1'b0 :
                          size_half ? offset_i[0] : (|offset_i);

    // Bring the addressed byte/half down to lane 0 before extending.
    assign shifted = load_word_i >> {offset_i, 3'b000};

    always_comb begin
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = load_word_i;
        if (size_byte) begin
            be_o        = 4'b0001 << offset_i;
            wdata_o     = {4{store_data_i[7:0]}};
            load_data_o = {{(P_WIDTH-8){sign_ext & shifted[7]}}, shifted[7:0]};
        end else if (size_half) begin
            be_o        = 4'b0011 << offset_i;
            wdata_o     = {2{store_data_i[15:0]}};
            load_data_o = {{(P_WIDTH-16){sign_ext & shifted[15]}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/memory_cycle.sv
// ----------------------------------------------------------------------------
// memory_cycle
//   Memory-access stage of the RV32I pipeline. Issues loads/stores over a
//   request/grant/response handshake, stalls the front of the pipeline while
//   an access is outstanding, and holds the MEM/WB pipeline register.
//   Ports:
//     i_clk, i_rst            clock, synchronous active-high reset
//     i_*_m                   instruction fields from EX/MEM
//     o_dmem_*, i_dmem_*      data-memory handshake
//     o_stall_m               hold IF/ID/EX/MEM registers
//     o_*_w                   MEM/WB register fields
//     o_mem_state             current access FSM state (observability)
//
//   Handshake: o_dmem_req stays high with stable addr/we/be/wdata until the
//   cycle i_dmem_gnt is seen; a granted load then waits for i_dmem_rvalid,
//   which the memory returns at least one cycle after the grant. Only one
//   access is ever outstanding; rvalid outside WAIT_RVALID is ignored.
// ----------------------------------------------------------------------------
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int P_WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid_m,
    input  logic [P_WIDTH-1:0] i_alu_result_m,
    input  logic [P_WIDTH-1:0] i_write_data_m,
    input  logic               i_mem_read_m,
    input  logic               i_mem_write_m,
    input  logic [2:0]         i_funct3_m,
    input  logic [4:0]         i_rd_m,
    input  logic               i_reg_write_m,
    input  logic [1:0]         i_resultsrc_m,
    input  logic [P_WIDTH-1:0] i_pc_plus_4_m,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [P_WIDTH-1:0] o_dmem_addr,
    output logic [P_WIDTH-1:0] o_dmem_wdata,
    output logic [3:0]         o_dmem_be,
    input  logic               i_dmem_gnt,
    input  logic               i_dmem_rvalid,
    input  logic [P_WIDTH-1:0] i_dmem_rdata,
    output logic               o_stall_m,
    output logic [P_WIDTH-1:0] o_alu_result_w,
    output logic [P_WIDTH-1:0] o_mem_data_w,
    output logic [P_WIDTH-1:0] o_pc_plus_4_w,
    output logic [1:0]         o_resultsrc_w,
    output logic [4:0]         o_rd_w,
    output logic               o_reg_write_w,
    output logic               o_valid_w,
    output logic               o_misaligned_w,
    output mem_state_t         o_mem_state
);

    logic               is_load;
    logic               is_store;
    logic               mem_op;
    logic               misaligned;
    logic               access;
    logic [3:0]         be;
    logic [P_WIDTH-1:0] wdata;
    logic [P_WIDTH-1:0] load_data;

    // A request with both read and write set is handled as a load.
    assign is_load  = i_mem_read_m;
    assign is_store = i_mem_write_m & ~i_mem_read_m;
    assign mem_op   = i_valid_m & (i_mem_read_m | i_mem_write_m);
    assign access   = mem_op & ~misaligned;

    memory_cycle_lsu_align #(.P_WIDTH(P_WIDTH)) u_align (
        .is_store_i   (is_store),
        .funct3_i     (i_funct3_m),
        .offset_i     (i_alu_result_m[1:0]),
        .store_data_i (i_write_data_m),
        .load_word_i  (i_dmem_rdata),
        .be_o         (be),
        .wdata_o      (wdata),
        .load_data_o  (load_data),
        .misaligned_o (misaligned)
    );

    mem_state_t         state_q, state_d;
    logic               stall;
    logic               req;

    logic [P_WIDTH-1:0] alu_result_q, alu_result_d;
    logic [P_WIDTH-1:0] mem_data_q,   mem_data_d;
    logic [P_WIDTH-1:0] pc_plus_4_q,  pc_plus_4_d;
    logic [1:0]         resultsrc_q,  resultsrc_d;
    logic [4:0]         rd_q,         rd_d;
    logic               reg_write_q,  reg_write_d;
    logic               valid_q,      valid_d;
    logic               misaligned_q, misaligned_d;

    // Access FSM. Stall is the inverse of "instruction completes this cycle";
    // a store granted from WAIT_GNT completes in that cycle, so the stage
    // releases the stall there instead of re-presenting the same store.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (i_dmem_gnt) begin
                        if (is_load) begin
                            state_d = WAIT_RVALID;
                            stall   = 1'b1;
                        end
                    end else begin
                        state_d = WAIT_GNT;
                        stall   = 1'b1;
                    end
                end
            end
            WAIT_GNT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (i_dmem_gnt) begin
                    if (is_load) begin
                        state_d = WAIT_RVALID;
                    end else begin
                        state_d = IDLE;
                        stall   = 1'b0;
                    end
                end
            end
            WAIT_RVALID: begin
                stall = ~i_dmem_rvalid;
                if (i_dmem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MEM/WB next value: a zero bubble while stalled, otherwise the
    // instruction in MEM. Load data is only valid on the rvalid cycle.
    always_comb begin
        alu_result_d = '0;
        mem_data_d   = '0;
        pc_plus_4_d  = '0;
        resultsrc_d  = '0;
        rd_d         = '0;
        reg_write_d  = 1'b0;
        valid_d      = 1'b0;
        misaligned_d = 1'b0;
        if (!stall) begin
            alu_result_d = i_alu_result_m;
            pc_plus_4_d  = i_pc_plus_4_m;
            resultsrc_d  = i_resultsrc_m;
            rd_d         = i_rd_m;
            valid_d      = i_valid_m;
            misaligned_d = mem_op & misaligned;
            reg_write_d  = i_valid_m & i_reg_write_m & ~(mem_op & misaligned);
            mem_data_d   = (state_q == WAIT_RVALID) ? load_data : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            pc_plus_4_q  <= '0;
            resultsrc_q  <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            pc_plus_4_q  <= pc_plus_4_d;
            resultsrc_q  <= resultsrc_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Bus fields are driven only for a real access so idle/ALU cycles stay 0.
    assign o_dmem_req   = req;
    assign o_dmem_we    = access & is_store;
    assign o_dmem_addr  = access ? {i_alu_result_m[P_WIDTH-1:2], 2'b00} : '0;
    assign o_dmem_wdata = (access & is_store) ? wdata : '0;
    assign o_dmem_be    = access ? be : 4'b0000;
    assign o_stall_m    = stall;

    assign o_alu_result_w = alu_result_q;
    assign o_mem_data_w   = mem_data_q;
    assign o_pc_plus_4_w  = pc_plus_4_q;
    assign o_resultsrc_w  = resultsrc_q;
    assign o_rd_w         = rd_q;
    assign o_reg_write_w  = reg_write_q;
    assign o_valid_w      = valid_q;
    assign o_misaligned_w = misaligned_q;
    assign o_mem_state    = state_q;

endmodule

// File: tb/tb_memory_cycle.sv
// ----------------------------------------------------------------------------
// tb_memory_cycle
//   Self-checking bench for memory_cycle. The bench plays the data memory
//   and predicts each instruction's bus activity, stall profile and
//   write-back from access-size / alignment arithmetic.
// ----------------------------------------------------------------------------
module tb_memory_cycle;
    import memory_cycle_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid_m;
    logic [31:0] i_alu_result_m;
    logic [31:0] i_write_data_m;
    logic        i_mem_read_m;
    logic        i_mem_write_m;
    logic [2:0]  i_funct3_m;
    logic [4:0]  i_rd_m;
    logic        i_reg_write_m;
    logic [1:0]  i_resultsrc_m;
    logic [31:0] i_pc_plus_4_m;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_stall_m;
    logic [31:0] o_alu_result_w;
    logic [31:0] o_mem_data_w;
    logic [31:0] o_pc_plus_4_w;
    logic [1:0]  o_resultsrc_w;
    logic [4:0]  o_rd_w;
    logic        o_reg_write_w;
    logic        o_valid_w;
    logic        o_misaligned_w;
    mem_state_t  o_mem_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock
    always #5 clk = ~clk;

    memory_cycle #(.P_WIDTH(32)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_valid_m      (i_valid_m),
        .i_alu_result_m (i_alu_result_m),
        .i_write_data_m (i_write_data_m),
        .i_mem_read_m   (i_mem_read_m),
        .i_mem_write_m  (i_mem_write_m),
        .i_funct3_m     (i_funct3_m),
        .i_rd_m         (i_rd_m),
        .i_reg_write_m  (i_reg_write_m),
        .i_resultsrc_m  (i_resultsrc_m),
        .i_pc_plus_4_m  (i_pc_plus_4_m),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_wdata   (o_dmem_wdata),
        .o_dmem_be      (o_dmem_be),
        .i_dmem_gnt     (i_dmem_gnt),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_stall_m      (o_stall_m),
        .o_alu_result_w (o_alu_result_w),
        .o_mem_data_w   (o_mem_data_w),
        .o_pc_plus_4_w  (o_pc_plus_4_w),
        .o_resultsrc_w  (o_resultsrc_w),
        .o_rd_w         (o_rd_w),
        .o_reg_write_w  (o_reg_write_w),
        .o_valid_w      (o_valid_w),
        .o_misaligned_w (o_misaligned_w),
        .o_mem_state    (o_mem_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input bit st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        int          sz = acc_size(1'b0, f3);
        logic [31:0] v  = w >> (8 * off);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] exp_be(input int sz, input int off);
        logic [3:0] b = 4'b0000;
        for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + sz);
        return b;
    endfunction

    // ---------------- driver: one instruction through MEM ----------------
    // kind: 0 = ALU, 1 = load, 2 = store. g = cycles before grant,
    // k = cycles from grant to rvalid (loads only).
    task automatic do_instr(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] word, input int g,
                            input int k, input logic [4:0] rd, input logic [1:0] rs,
                            input logic [31:0] pc4);
        bit ld  = (kind == 1);
        bit st  = (kind == 2);
        int sz  = acc_size(st, f3);
        int off = int'(addr[1:0]);
        bit mis = (ld || st) && ((off % sz) != 0);
        bit acc = (ld || st) && !mis;
        int n   = !acc ? 1 : (ld ? g + k + 1 : g + 1);
        for (int c = 0; c < n; c++) begin
            i_valid_m      = 1'b1;
            i_alu_result_m = addr;
            i_write_data_m = wd;
            i_mem_read_m   = ld;
            i_mem_write_m  = st;
            i_funct3_m     = f3;
            i_rd_m         = rd;
            i_reg_write_m  = !st;
            i_resultsrc_m  = rs;
            i_pc_plus_4_m  = pc4;
            i_dmem_gnt     = acc && (c == g);
            // rvalid before the grant must be ignored by the stage
            i_dmem_rvalid  = (acc && ld && (c == g + k)) ||
                             (acc && (c < g) && ($urandom_range(0, 1) == 1));
            i_dmem_rdata   = (acc && ld && (c == g + k)) ? word : $urandom();
            #1;
            chk("req", 32'(o_dmem_req), 32'(acc && (c <= g)));
            chk("stall", 32'(o_stall_m), 32'(c < n - 1));
            if (acc && (c <= g)) begin
                chk("addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
                chk("we", 32'(o_dmem_we), 32'(st));
                chk("be", 32'(o_dmem_be), 32'(exp_be(sz, off)));
                if (st) chk("wdata", o_dmem_wdata, exp_wdata(sz, wd));
            end
            @(posedge clk);
            #1;
            if (c < n - 1) begin
                chk("bubble_valid", 32'(o_valid_w), 32'd0);
                chk("bubble_regwr", 32'(o_reg_write_w), 32'd0);
            end else begin
                chk("wb_valid", 32'(o_valid_w), 32'd1);
                chk("wb_regwr", 32'(o_reg_write_w), 32'(!st && !mis));
                chk("wb_misaligned", 32'(o_misaligned_w), 32'(mis));
                chk("wb_alu", o_alu_result_w, addr);
                chk("wb_pc4", o_pc_plus_4_w, pc4);
                chk("wb_rd", 32'(o_rd_w), 32'(rd));
                chk("wb_rs", 32'(o_resultsrc_w), 32'(rs));
                chk("wb_memdata", o_mem_data_w, (acc && ld) ? exp_load(f3, off, word) : 32'd0);
            end
        end
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
    endtask

    task automatic idle_inputs();
        i_valid_m      = 1'b0;
        i_alu_result_m = '0;
        i_write_data_m = '0;
        i_mem_read_m   = 1'b0;
        i_mem_write_m  = 1'b0;
        i_funct3_m     = '0;
        i_rd_m         = '0;
        i_reg_write_m  = 1'b0;
        i_resultsrc_m  = '0;
        i_pc_plus_4_m  = '0;
        i_dmem_gnt     = 1'b0;
        i_dmem_rvalid  = 1'b0;
        i_dmem_rdata   = '0;
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, "_alu"},   o_alu_result_w, 32'd0);
        chk({tag, "_mem"},   o_mem_data_w, 32'd0);
        chk({tag, "_pc4"},   o_pc_plus_4_w, 32'd0);
        chk({tag, "_rs"},    32'(o_resultsrc_w), 32'd0);
        chk({tag, "_rd"},    32'(o_rd_w), 32'd0);
        chk({tag, "_regwr"}, 32'(o_reg_write_w), 32'd0);
        chk({tag, "_valid"}, 32'(o_valid_w), 32'd0);
        chk({tag, "_mis"},   32'(o_misaligned_w), 32'd0);
        chk({tag, "_state"}, 32'(o_mem_state), 32'(IDLE));
    endtask

    initial begin
        // Reset
        idle_inputs();
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_wb_zero("reset");
        chk("reset_req", 32'(o_dmem_req), 32'd0);
        chk("reset_stall", 32'(o_stall_m), 32'd0);
        chk("reset_addr", o_dmem_addr, 32'd0);
        chk("reset_be", 32'(o_dmem_be), 32'd0);
        i_rst = 1'b0;

        // ALU instruction
        do_instr(0, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 5'd5, RES_ALU, 32'h0000_0104);
        // SB at 0x103, immediate grant
        do_instr(2, F3_SB, 32'h0000_0103, 32'h0000_00AB, 32'h0, 0, 0, 5'd0, RES_ALU, 32'h108);
        // LB / LBU at 0x102, rvalid two cycles after grant
        do_instr(1, F3_LB,  32'h0000_0102, 32'h0, 32'h0080_0000, 0, 2, 5'd7, RES_MEM, 32'h10C);
        do_instr(1, F3_LBU, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 2, 5'd8, RES_MEM, 32'h110);
        // LW with grant delayed three cycles
        do_instr(1, F3_LW, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 3, 1, 5'd9, RES_MEM, 32'h114);
        // Misaligned LH
        do_instr(1, F3_LH, 32'h0000_0101, 32'h0, 32'h1234_5678, 0, 1, 5'd10, RES_MEM, 32'h118);
        // SH with delayed grant, LH sign-extended from upper half
        do_instr(2, F3_SH, 32'h0000_0302, 32'h0000_BEEF, 32'h0, 2, 0, 5'd0, RES_ALU, 32'h11C);
        do_instr(1, F3_LH, 32'h0000_0302, 32'h0, 32'h9ABC_0000, 1, 3, 5'd11, RES_MEM, 32'h120);
        // Bubble cycle
        idle_inputs();
        #1;
        chk("bubble_req", 32'(o_dmem_req), 32'd0);
        chk("bubble_stall", 32'(o_stall_m), 32'd0);
        @(posedge clk);
        #1;
        chk("bubble_wb_valid", 32'(o_valid_w), 32'd0);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            int kind = $urandom_range(0, 2);
            do_instr(kind, 3'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom(),
                     $urandom_range(0, 3), $urandom_range(1, 3), 5'($urandom_range(0, 31)),
                     (kind == 1) ? RES_MEM : 2'($urandom_range(0, 3)), $urandom());
        end

        // Reset while waiting for rvalid; late rvalid must be ignored
        idle_inputs();
        i_valid_m      = 1'b1;
        i_mem_read_m   = 1'b1;
        i_reg_write_m  = 1'b1;
        i_funct3_m     = F3_LW;
        i_alu_result_m = 32'h0000_0400;
        i_rd_m         = 5'd12;
        i_resultsrc_m  = RES_MEM;
        i_dmem_gnt     = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pre_state", 32'(o_mem_state), 32'(WAIT_RVALID));
        i_dmem_gnt = 1'b0;
        i_rst      = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        idle_inputs();
        chk_wb_zero("rst_wait");
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("late_req", 32'(o_dmem_req), 32'd0);
        chk("late_stall", 32'(o_stall_m), 32'd0);
        @(posedge clk);
        #1;
        i_dmem_rvalid = 1'b0;
        chk_wb_zero("late_rvalid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the stimulus is finite, this only guards against a lockup.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory-access stage of the five-stage RV32I pipeline, between the execute stage and the write-back stage. It issues loads and stores to the data memory over a request/grant/response handshake, generates byte enables and store-data lane placement, and sign- or zero-extends load data. It stalls the front of the pipeline while an access is outstanding. It also holds the MEM/WB pipeline register that drives write-back (ALU result, memory data, PC+4, result-select).

## Interface
- P_WIDTH, 32, datapath and address width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid_m  in  1  instruction in MEM is valid
- i_alu_result_m  in  P_WIDTH  effective address, or ALU result for non-memory instructions
- i_write_data_m  in  P_WIDTH  store source register (rs2)
- i_mem_read_m / i_mem_write_m  in  1 each  load / store instruction
- i_funct3_m  in  3  access size and sign
- i_rd_m  in  5  destination register
- i_reg_write_m  in  1  register write enable
- i_resultsrc_m  in  2  write-back select: bit0 = memory, bit1 = PC+4
- i_pc_plus_4_m  in  P_WIDTH  PC+4
- o_dmem_req  out  1  access request
- o_dmem_we  out  1  write access
- o_dmem_addr  out  P_WIDTH  word-aligned address, bits[1:0] = 0
- o_dmem_wdata  out  P_WIDTH  lane-placed store data
- o_dmem_be  out  4  byte enables
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  P_WIDTH  load word
- o_stall_m  out  1  hold IF/ID/EX/MEM registers
- o_alu_result_w, o_mem_data_w, o_pc_plus_4_w  out  P_WIDTH  MEM/WB register fields
- o_resultsrc_w  out  2  MEM/WB result select
- o_rd_w  out  5  MEM/WB destination register
- o_reg_write_w  out  1  MEM/WB register write enable
- o_valid_w  out  1  MEM/WB valid
- o_misaligned_w  out  1  misaligned-access flag, travels with the instruction

## Operation
- Access condition: access = i_valid_m & (i_mem_read_m | i_mem_write_m) & !misaligned.
- Misaligned cases:
  - LH, LHU, SH with addr[0] = 1.
  - LW, SW with addr[1:0] != 0.
  - A misaligned access issues no request, advances in 1 cycle, and sets o_misaligned_w=1 and o_reg_write_w=0.
- Store placement by funct3 and byte offset off = addr[1:0]:
  - SB: wdata = byte replicated ×4; be = 4'b0001 << off.
  - SH: wdata = half replicated ×2; be = 4'b0011 << off.
  - SW: wdata = word; be = 4'b1111.
- Load extraction uses the same offset:
  - LB / LBU: byte at off, sign- / zero-extended.
  - LH / LHU: half at off, sign- / zero-extended.
  - LW: whole word.
  - Unlisted funct3 values are treated as LW/SW.
- FSM (state reg, reset to IDLE):
  - IDLE, when access:
    - o_dmem_req=1.
    - Store with gnt: complete, stay in IDLE.
    - Store without gnt: go to WAIT_GNT.
    - Load with gnt: go to WAIT_RVALID.
    - Load without gnt: go to WAIT_GNT.
  - WAIT_GNT:
    - req=1, address/data/be held from the stable stage inputs.
    - On gnt: a load goes to WAIT_RVALID; a store completes and returns to IDLE.
  - WAIT_RVALID:
    - req=0.
    - On rvalid: capture the formatted data into o_mem_data_w and return to IDLE.
- o_stall_m = 1 while the current instruction has not completed:
  - IDLE: 1 for a load; 1 for a store without gnt.
  - WAIT_GNT: 1.
  - WAIT_RVALID: !i_dmem_rvalid.
- While stalled, upstream holds all i_*_m inputs stable. The MEM/WB register loads a bubble each stalled cycle: o_valid_w=0, o_reg_write_w=0, other fields don't-care.
- MEM/WB register loads the instruction on the completion edge.
- o_mem_data_w is 0 for non-load instructions.
- Exactly one outstanding access. i_dmem_rvalid seen in IDLE or WAIT_GNT is ignored.

## Timing
- Reset: state IDLE, every MEM/WB output 0. Combinational dmem outputs are 0 unless i_valid_m is set.
- Non-memory, misaligned, or store granted in the same cycle: 1-cycle latency, no stall.
- Load granted in cycle N with rvalid in cycle N+k (k≥1): stall cycles N..N+k-1; WB valid at N+k+1.
- gnt and rvalid never assert in the same cycle for the same load. The memory returns rvalid ≥1 cycle after gnt.
- Reset in WAIT_GNT or WAIT_RVALID:
  - Abandons the access and returns to IDLE.
  - A late rvalid is ignored.
  - No write-back occurs.

## Structure
- Shared pipeline package holds:
  - funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - The mem_state_t enum {IDLE, WAIT_GNT, WAIT_RVALID}.
  - The resultsrc encoding constants.
- Natural sub-module: lsu_align, purely combinational. It takes funct3, offset, store data and load word, and produces be, placed wdata, extended load data and misaligned. The top level holds the FSM and the MEM/WB register.

## Test plan
- ALU instruction, result 0x0000_1234, rd=5: no req, no stall; next cycle o_alu_result_w=0x1234, o_rd_w=5, o_valid_w=1.
- SB at addr 0x103, data 0xAB, gnt same cycle: be=4'b1000, wdata=0xABABABAB, o_dmem_addr=0x100, no stall.
- LB at 0x102, gnt immediate, rvalid 2 cycles later with rdata 0x0080_0000: o_stall_m high 2 cycles; o_mem_data_w=0xFFFF_FF80. LBU of the same word returns 0x0000_0080.
- LW with gnt delayed 3 cycles: req and addr held stable; o_valid_w=0 bubbles during the stall; final data matches.
- LH at 0x101: no req, o_misaligned_w=1, o_reg_write_w=0, 1-cycle latency.
- Reset asserted in WAIT_RVALID, then rvalid arrives after reset: state IDLE, all outputs 0, no write-back.
